// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller.
// Operands are latched on accept and stepped LSB-first through one 1-bit
// full adder, one bit per clock. A carry flop links consecutive bit steps.
// result/cout/ovf are loaded only on the MSB step, together with a one-cycle
// done pulse, so they never show partial values.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; operands are latched on the accepting edge
// S_RUN  | one bit per edge, LSB first; the MSB step ends the operation
// S_DONE | result valid, done pulse high; always returns to S_IDLE

module serial_adder_fa (
  input  logic ai,
  input  logic bi,
  input  logic cini,
  output logic si,
  output logic couti
);

  // behavioural 1-bit full adder
  always_comb begin
    si    = ai ^ bi ^ cini;
    couti = (ai & bi) | (ai & cini) | (bi & cini);
  end

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             si;
  logic             couti;
  logic             accept;
  logic             last_step;

  assign accept    = (state == S_IDLE) && start;
  assign last_step = (state == S_RUN) && (count == LAST);

  serial_adder_fa u_fa (
    .ai    (sa[0]),
    .bi    (sb[0]),
    .cini  (carry),
    .si    (si),
    .couti (couti)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; start outside IDLE is dropped, not queued
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (count == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // status outputs decoded from state only, so no input-to-output path
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // shift datapath; subtract is a + ~b + 1, with the +1 entering as the initial carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      carry  <= 1'b0;
      count  <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        sa    <= a;
        sb    <= op ? ~b : b;
        carry <= op;
        count <= '0;
        sr    <= '0;
      end else if (state == S_RUN) begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        sr    <= {si, sr[WIDTH-1:1]};
        carry <= couti;
        count <= count + 1'b1;
      end
      if (last_step) begin
        result <= {si, sr[WIDTH-1:1]};
        cout   <= couti;
        ovf    <= carry ^ couti;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4.
// Expected values come from signed/unsigned integer arithmetic.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, op8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, result8;
  logic       start4, op4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, result4;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4)
  );

  // reference: plain integer arithmetic on the w-bit operands
  function automatic void model(input int w, input int x, input int y, input bit sub,
                                output int r, output bit c, output bit v);
    int m, half, raw, sx, sy, t;
    m    = 1 << w;
    half = m / 2;
    raw  = sub ? x - y : x + y;
    r    = ((raw % m) + m) % m;
    c    = sub ? (x >= y) : (raw >= m);
    sx   = (x >= half) ? x - m : x;
    sy   = (y >= half) ? y - m : y;
    t    = sub ? sx - sy : sx + sy;
    v    = (t < -half) || (t >= half);
  endfunction

  task automatic sample(input int w, output logic [7:0] r, output logic c, output logic v,
                        output logic bz, output logic dn);
    if (w == 8) begin
      r = result8; c = cout8; v = ovf8; bz = busy8; dn = done8;
    end else begin
      r = {4'b0, result4}; c = cout4; v = ovf4; bz = busy4; dn = done4;
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [7:0] x, input logic [7:0] y,
                       input logic o);
    if (w == 8) begin
      start8 = s; a8 = x; b8 = y; op8 = o;
    end else begin
      start4 = s; a4 = x[3:0]; b4 = y[3:0]; op4 = o;
    end
  endtask

  // one operation: latency, busy length, held outputs, final values, done pulse width
  task automatic do_op(input int w, input logic [7:0] xi, input logic [7:0] yi, input logic o,
                       input int pulse_at, input string name);
    logic [7:0] x, y, r, pr;
    logic       c, v, bz, dn, pc, pv;
    int         er, lat, bcnt;
    bit         ec, ev, held;
    x = (w == 8) ? xi : (xi & 8'h0F);
    y = (w == 8) ? yi : (yi & 8'h0F);
    model(w, int'(x), int'(y), o, er, ec, ev);
    @(posedge clk); #1;
    sample(w, pr, pc, pv, bz, dn);
    drive(w, 1'b1, x, y, o);
    @(posedge clk); #1;
    drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    lat = 0; bcnt = 0; held = 1'b1;
    sample(w, r, c, v, bz, dn);
    while (!dn && lat < 4 * w) begin
      if (bz) bcnt++;
      if (r !== pr || c !== pc || v !== pv) held = 1'b0;
      drive(w, 1'(lat == pulse_at), 8'($urandom), 8'($urandom), 1'($urandom));
      @(posedge clk); #1;
      lat++;
      sample(w, r, c, v, bz, dn);
    end
    if (bz) bcnt++;
    drive(w, 1'b0, x, y, o);
    checks++;
    if (lat !== w) begin
      errors++; $display("FAIL %s latency got %0d exp %0d", name, lat, w);
    end
    checks++;
    if (r !== 8'(er)) begin
      errors++; $display("FAIL %s result got %h exp %h", name, r, 8'(er));
    end
    checks++;
    if (c !== ec) begin
      errors++; $display("FAIL %s cout got %b exp %b", name, c, ec);
    end
    checks++;
    if (v !== ev) begin
      errors++; $display("FAIL %s ovf got %b exp %b", name, v, ev);
    end
    checks++;
    if (!held) begin
      errors++; $display("FAIL %s outputs changed during RUN (prev %h/%b/%b)", name, pr, pc, pv);
    end
    @(posedge clk); #1;
    sample(w, r, c, v, bz, dn);
    checks++;
    if (dn !== 1'b0 || bz !== 1'b0 || bcnt != w + 1) begin
      errors++;
      $display("FAIL %s done/busy after got done=%b busy=%b busy_cycles=%0d exp 0/0/%0d",
               name, dn, bz, bcnt, w + 1);
    end
    checks++;
    if (r !== 8'(er)) begin
      errors++; $display("FAIL %s result hold got %h exp %h", name, r, 8'(er));
    end
  endtask

  task automatic test_reset;
    logic [7:0] r;
    logic c, v, bz, dn;
    rst = 1'b1;
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    sample(8, r, c, v, bz, dn);
    checks++;
    if ({r, c, v, bz, dn} !== 12'h0) begin
      errors++; $display("FAIL reset8 got r=%h c=%b v=%b busy=%b done=%b exp all 0", r, c, v, bz, dn);
    end
    sample(4, r, c, v, bz, dn);
    checks++;
    if ({r, c, v, bz, dn} !== 12'h0) begin
      errors++; $display("FAIL reset4 got r=%h c=%b v=%b busy=%b done=%b exp all 0", r, c, v, bz, dn);
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    do_op(8, 8'h3C, 8'h05, 1'b0, -1, "add_3c_05");
    do_op(8, 8'h7F, 8'h01, 1'b0, -1, "add_7f_01");
    do_op(8, 8'hFF, 8'h01, 1'b0, -1, "add_ff_01");
  endtask

  task automatic test_sub;
    do_op(8, 8'h05, 8'h03, 1'b1, -1, "sub_05_03");
    do_op(8, 8'h03, 8'h05, 1'b1, -1, "sub_03_05");
    do_op(8, 8'h80, 8'h01, 1'b1, -1, "sub_80_01");
  endtask

  task automatic test_ignore_start;
    do_op(8, 8'h3C, 8'h05, 1'b0, 3, "ignore_start");
  endtask

  task automatic test_back_to_back;
    logic [7:0] r;
    logic c, v, bz, dn;
    int lat, d1, d2;
    @(posedge clk); #1;
    drive(8, 1'b1, 8'h3C, 8'h05, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b1, 8'h7F, 8'h01, 1'b0);
    lat = 0; d1 = -1; d2 = -1;
    while (lat < 40) begin
      sample(8, r, c, v, bz, dn);
      if (dn) begin
        if (d1 < 0) begin
          d1 = lat;
          checks++;
          if (r !== 8'h41) begin
            errors++; $display("FAIL b2b first result got %h exp 41", r);
          end
        end else begin
          d2 = lat;
          checks++;
          if (r !== 8'h80 || v !== 1'b1) begin
            errors++; $display("FAIL b2b second result got %h ovf %b exp 80 ovf 1", r, v);
          end
          break;
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    checks++;
    if (d1 != 8 || d2 != 18) begin
      errors++; $display("FAIL b2b done times got %0d,%0d exp 8,18", d1, d2);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++; $display("FAIL b2b idle after got busy=%b exp 0", busy8);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] r;
    logic c, v, bz, dn;
    bit seen;
    @(posedge clk); #1;
    drive(8, 1'b1, 8'h3C, 8'h05, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 8'h3C, 8'h05, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    sample(8, r, c, v, bz, dn);
    checks++;
    if ({r, c, v, bz, dn} !== 12'h0) begin
      errors++; $display("FAIL rst_mid got r=%h c=%b v=%b busy=%b done=%b exp all 0", r, c, v, bz, dn);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL rst_mid activity after reset got busy/done high exp idle");
    end
    do_op(8, 8'h3C, 8'h05, 1'b0, -1, "post_rst_add");
  endtask

  task automatic test_width4;
    do_op(4, 8'h07, 8'h01, 1'b0, -1, "w4_add_7_1");
    do_op(4, 8'h0F, 8'h01, 1'b0, -1, "w4_add_f_1");
    do_op(4, 8'h03, 8'h05, 1'b0, -1, "w4_add_3_5");
    do_op(4, 8'h08, 8'h01, 1'b1, -1, "w4_sub_8_1");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      do_op(8, 8'($urandom), 8'($urandom), 1'($urandom), -1, "rand8");
    for (int i = 0; i < 10; i++)
      do_op(4, 8'($urandom), 8'($urandom), 1'($urandom), -1, "rand4");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_width4();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract controller for the 8-bit calculator datapath. It latches two WIDTH-bit operands, then steps them LSB-first through a single instance of the team's 1-bit behavioural full adder, one bit per clock. A carry flip-flop closes the loop between bit steps. Result, carry-out and signed overflow are presented together with a one-cycle completion pulse, so the ALU sequencer can trade area for latency on add/sub.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = add (a+b), 1 = subtract (a−b)
- a  input  WIDTH  operand A, sampled on the accepting edge
- b  input  WIDTH  operand B, sampled on the accepting edge
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  sum/difference, held until the next completion
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a ≥ b unsigned)
- ovf  output  1  two's-complement overflow

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE → RUN on an edge with start=1:
  - Load shift register SA ← a.
  - Load shift register SB ← (op ? ~b : b).
  - Set carry ← op.
  - Set count ← 0.
  - Clear partial register SR.
- RUN, each edge:
  - The full adder takes ai=SA[0], bi=SB[0], cini=carry.
  - SA and SB shift right by one.
  - SR shifts right with si inserted at SR[WIDTH-1].
  - carry ← couti.
  - count ← count+1.
- RUN → DONE on the edge where count==WIDTH-1, which is the MSB step. On that edge:
  - result ← {si, SR[WIDTH-1:1]}.
  - cout ← couti.
  - ovf ← carry XOR couti, i.e. carry into MSB XOR carry out.
- DONE → IDLE unconditionally on the next edge.
- result, cout and ovf change only on the completion edge or on reset. They never show partial values.
- start in RUN or DONE is ignored and is not queued. a, b and op may change freely after the accepting edge.
- count width is ceil(log2(WIDTH)). It never wraps because it is reset on every accept.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, carry=0, count=0, SA=SB=SR=0.
- rst asserted at any time, including mid-RUN, immediately forces all of the above. The operation in flight is discarded with no done pulse.
- Let E0 be the accepting edge.
  - Bit i is computed on edge E(i+1), for i = 0..WIDTH-1.
  - The completion edge is E(WIDTH).
  - done=1 and the new result are visible in the cycle following E(WIDTH).
- Latency from start edge to done is WIDTH cycles. The WIDTH=8 default gives 8.
- busy rises after E0 and falls after E(WIDTH+1). It is high for WIDTH+1 cycles.
- done is high exactly one cycle per operation.
- Minimum accept-to-accept spacing is WIDTH+2 edges. start held high continuously therefore restarts on E(WIDTH+2), using the a/b/op values present at that edge.
- The full-adder path is purely combinational between registers. No other combinational path runs from inputs to outputs.

## Test plan
- Add 0x3C + 0x05 (WIDTH=8) → result=0x41, cout=0, ovf=0. done is seen exactly 8 cycles after the start edge; busy is high for 9 cycles.
- Overflow and wrap-around cases:
  - Add 0x7F + 0x01 → result=0x80, cout=0, ovf=1.
  - Add 0xFF + 0x01 → result=0x00, cout=1, ovf=0.
- Subtract cases:
  - 0x05 − 0x03 → result=0x02, cout=1, ovf=0.
  - 0x03 − 0x05 → result=0xFE, cout=0, ovf=0.
  - 0x80 − 0x01 → result=0x7F, cout=1, ovf=1.
- Pulse start mid-RUN with different operands → ignored. The original result appears on schedule. Holding start high back-to-back → the second accept happens on E(10) and the second done follows 8 cycles later.
- Assert rst for one cycle at count=4 during 0x3C + 0x05 → all outputs are 0 immediately, no done pulse, state is IDLE. A fresh start then completes correctly with 0x41.
- Check that result/cout/ovf stay at the previous values throughout RUN. Rerun the add cases at WIDTH=4 (0x7 + 0x1 → 0x8, ovf=1, latency 4).
